// File: rtl/filter_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : filter_window_feeder
//  Description : Builds 3x3 pixel windows from a raster stream, writes each
//                window to an Avalon-MM filter, reads back the filtered pixel.
//                Optional window counter: FILTER_FEEDER_WINDOW_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_window_feeder #(
    parameter int IMG_WIDTH     = 640,
    parameter int BIT_PER_PIXEL = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3*BIT_PER_PIXEL-1:0] in_data,
    input  logic                       in_sof,
    output logic [4:0]                 avm_address,
    output logic                       avm_write,
    output logic [31:0]                avm_writedata,
    output logic                       avm_read,
    input  logic [31:0]                avm_readdata,
    input  logic                       avm_waitrequest,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_PER_PIXEL-1:0]   out_data,
    output logic [31:0]                window_count
);

    localparam int c_PIX_W = 3 * BIT_PER_PIXEL;
    localparam int c_COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);

    localparam logic [1:0] c_FILL  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_OUT   = 2'd3;

    logic [1:0]               r_state;
    logic [c_COL_W-1:0]       r_col;
    logic [1:0]               r_row;
    logic [3:0]               r_idx;
    logic [BIT_PER_PIXEL-1:0] r_out_data;
    logic [c_PIX_W-1:0]       r_win [9];
    logic [c_PIX_W-1:0]       r_lb1 [IMG_WIDTH];
    logic [c_PIX_W-1:0]       r_lb2 [IMG_WIDTH];

    logic                     w_accept;
    logic [c_COL_W-1:0]       w_col;
    logic [1:0]               w_row;
    logic [c_PIX_W-1:0]       w_above1;
    logic [c_PIX_W-1:0]       w_above2;
    logic                     w_win_done;
    logic                     w_wr_done;
    logic                     w_unused_rd;

    // A start-of-frame pixel is placed at (0,0) no matter where the counters were.
    assign w_accept   = in_valid & in_ready;
    assign w_col      = in_sof ? '0 : r_col;
    assign w_row      = in_sof ? 2'd0 : r_row;
    assign w_above1   = r_lb1[w_col];
    assign w_above2   = r_lb2[w_col];
    assign w_win_done = w_accept && (w_col >= c_COL_TWO) && (w_row == 2'd2);
    assign w_wr_done  = avm_write && !avm_waitrequest;

    assign in_ready      = (r_state == c_FILL);
    assign avm_write     = (r_state == c_WRITE);
    assign avm_read      = (r_state == c_READ);
    assign avm_address   = avm_write ? {1'b0, r_idx} : 5'd0;
    assign avm_writedata = avm_write ? 32'(r_win[r_idx]) : 32'h0;
    assign out_valid     = (r_state == c_OUT);
    assign out_data      = r_out_data;
    assign w_unused_rd   = &{1'b0, avm_readdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_FILL;
            r_col      <= '0;
            r_row      <= 2'd0;
            r_idx      <= 4'd0;
            r_out_data <= '0;
        end else begin
            if (w_accept) begin
                if (w_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
                end else begin
                    r_col <= w_col + c_COL_W'(1);
                    r_row <= w_row;
                end
            end
            case (r_state)
                c_FILL: begin
                    r_idx <= 4'd0;
                    if (w_win_done) begin
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    if (w_wr_done) begin
                        if (r_idx == 4'd8) begin
                            r_idx   <= 4'd0;
                            r_state <= c_READ;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_READ: begin
                    if (!avm_waitrequest) begin
                        r_out_data <= avm_readdata[BIT_PER_PIXEL-1:0];
                        r_state    <= c_OUT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state <= c_FILL;
                    end
                end
            endcase
        end
    end

    // Line buffers and window shift register; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[w_col] <= w_above1;
            r_lb1[w_col] <= in_data;
            r_win[0]     <= r_win[1];
            r_win[1]     <= r_win[2];
            r_win[2]     <= w_above2;
            r_win[3]     <= r_win[4];
            r_win[4]     <= r_win[5];
            r_win[5]     <= w_above1;
            r_win[6]     <= r_win[7];
            r_win[7]     <= r_win[8];
            r_win[8]     <= in_data;
        end
    end

`ifdef FILTER_FEEDER_WINDOW_COUNT_EN
    logic [31:0] r_win_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= 32'h0;
        end else if (w_accept && in_sof) begin
            r_win_cnt <= 32'h0;
        end else if (out_valid && out_ready) begin
            r_win_cnt <= r_win_cnt + 32'h1;
        end
    end

    assign window_count = r_win_cnt;
`else
    assign window_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_filter_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_window_feeder
//  Description : Directed self-checking bench for filter_window_feeder (IMG_WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_window_feeder;

`ifdef FILTER_FEEDER_WINDOW_COUNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = 24'h0;
    logic        in_sof = 1'b0;
    logic [4:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [31:0] window_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] r_exp [9];

    filter_window_feeder #(
        .IMG_WIDTH     (4),
        .BIT_PER_PIXEL (8)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_sof          (in_sof),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .window_count    (window_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one pixel and returns #1 after the edge that accepts it.
    task automatic send(input logic [23:0] d, input logic sof);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_offer", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Follows a full window transaction starting in WRITE; checks every cycle.
    task automatic do_window(input int sidx, input int sn, input logic [7:0] rd,
                             input int hold, input int cnt);
        for (int i = 0; i < 9; i++) begin
            int stalls;
            stalls = (i == sidx) ? sn : 0;
            for (int s = 0; s <= stalls; s++) begin
                avm_waitrequest = (s < stalls);
                @(negedge clk);
                check("wr_write", {31'h0, avm_write}, 32'h1);
                check("wr_read",  {31'h0, avm_read}, 32'h0);
                check("wr_addr",  {27'h0, avm_address}, i);
                check("wr_data",  avm_writedata, {8'h00, r_exp[i]});
                @(posedge clk);
                #1;
            end
        end
        avm_waitrequest = 1'b0;
        avm_readdata    = {24'hABCDEF, rd};
        @(negedge clk);
        check("rd_read",  {31'h0, avm_read}, 32'h1);
        check("rd_write", {31'h0, avm_write}, 32'h0);
        check("rd_addr",  {27'h0, avm_address}, 32'h0);
        @(posedge clk);
        #1;
        avm_readdata = 32'h0;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_data",  {24'h0, out_data}, {24'h0, rd});
            check("hold_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid", {31'h0, out_valid}, 32'h1);
        check("out_data",  {24'h0, out_data}, {24'h0, rd});
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_in_ready",  {31'h0, in_ready}, 32'h1);
        check("post_out_valid", {31'h0, out_valid}, 32'h0);
        check("window_count",   window_count, c_CNT_EN ? cnt : 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {31'h0, in_ready}, 32'h1);
        check("rst_write",     {31'h0, avm_write}, 32'h0);
        check("rst_read",      {31'h0, avm_read}, 32'h0);
        check("rst_addr",      {27'h0, avm_address}, 32'h0);
        check("rst_wdata",     avm_writedata, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data",  {24'h0, out_data}, 32'h0);
        check("rst_count",     window_count, 32'h0);

        // First frame: 4 pixels per row, first window after pixel 10
        for (int k = 0; k <= 10; k++) begin
            send(24'(k), k == 0);
            if (k < 10) check("no_early_win", {31'h0, avm_write}, 32'h0);
        end
        r_exp = '{24'd0, 24'd1, 24'd2, 24'd4, 24'd5, 24'd6, 24'd8, 24'd9, 24'd10};
        do_window(99, 0, 8'h5A, 10, 1);

        // Next window, filter stalls 5 cycles on address 3
        send(24'd11, 1'b0);
        r_exp = '{24'd1, 24'd2, 24'd3, 24'd5, 24'd6, 24'd7, 24'd9, 24'd10, 24'd11};
        do_window(3, 5, 8'hC3, 0, 2);

        // Columns 0,1 of a row never complete a window
        send(24'd12, 1'b0);
        check("no_win_c0", {31'h0, avm_write}, 32'h0);
        send(24'd13, 1'b0);
        check("no_win_c1", {31'h0, avm_write}, 32'h0);

        // Start of frame lands where a window would otherwise complete
        send(24'd100, 1'b1);
        check("sof_no_win", {31'h0, avm_write}, 32'h0);
        check("sof_count",  window_count, 32'h0);
        for (int j = 1; j < 10; j++) begin
            send(24'(100 + j), 1'b0);
            check("sof_fill_no_win", {31'h0, avm_write}, 32'h0);
        end
        send(24'd110, 1'b0);
        r_exp = '{24'd100, 24'd101, 24'd102, 24'd104, 24'd105, 24'd106,
                  24'd108, 24'd109, 24'd110};
        do_window(99, 0, 8'h11, 2, 1);

        // Reset in the middle of a write burst
        send(24'd111, 1'b0);
        check("pre_rst_write", {31'h0, avm_write}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_write",    {31'h0, avm_write}, 32'h0);
        check("async_in_ready", {31'h0, in_ready}, 32'h1);
        check("async_count",    window_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after_rst_read", {31'h0, avm_read}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
